// File: rtl/pipe_stage_reg.sv
// Pipeline boundary register with flush (Req), stall (bubble or hold) and Tnew countdown.
// Optional stall-edge counter on bubble_cnt when PIPE_BUBBLE_CNT_EN is defined.
module pipe_stage_reg #(
  parameter int          DATA_W     = 96,
  parameter int          TNEW_W     = 2,
  parameter int          STALL_MODE = 0,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Req,
  input  logic              stall,
  input  logic [31:0]       in_instr,
  input  logic [31:0]       in_pc,
  input  logic [DATA_W-1:0] in_data,
  input  logic [4:0]        in_wa,
  input  logic [TNEW_W-1:0] in_tnew,
  input  logic              in_bd,
  input  logic [4:0]        in_exccode,
  input  logic              in_ri,
  input  logic              in_syscall,
  output logic [31:0]       out_instr,
  output logic [31:0]       out_pc,
  output logic [DATA_W-1:0] out_data,
  output logic [4:0]        out_wa,
  output logic [TNEW_W-1:0] out_tnew,
  output logic              out_bd,
  output logic [4:0]        out_exccode,
  output logic              out_valid
`ifdef PIPE_BUBBLE_CNT_EN
  ,
  output logic [15:0]       bubble_cnt
`endif
);

  typedef struct packed {
    logic [31:0]       instr;
    logic [31:0]       pc;
    logic [DATA_W-1:0] data;
    logic [4:0]        wa;
    logic [TNEW_W-1:0] tnew;
    logic              bd;
    logic [4:0]        exccode;
    logic              valid;
  } stage_t;

  localparam logic [4:0] EXC_RI  = 5'd10;
  localparam logic [4:0] EXC_SYS = 5'd8;

  stage_t st_q, st_d;

  always_comb begin
    st_d = st_q;
    if (Req) begin
      st_d    = '0;
      st_d.pc = HANDLER_PC;
    end else if (stall) begin
      // Bubble keeps PC/BD so a later exception on it still reports a sane EPC.
      if (STALL_MODE == 0) begin
        st_d    = '0;
        st_d.pc = in_pc;
        st_d.bd = in_bd;
      end
    end else begin
      st_d.instr = in_ri ? 32'h0 : in_instr;
      st_d.pc    = in_pc;
      st_d.data  = in_data;
      st_d.wa    = in_wa;
      st_d.tnew  = (in_tnew == '0) ? '0 : in_tnew - TNEW_W'(1);
      st_d.bd    = in_bd;
      st_d.valid = 1'b1;
      if (in_exccode != 5'd0) st_d.exccode = in_exccode;
      else if (in_ri)         st_d.exccode = EXC_RI;
      else if (in_syscall)    st_d.exccode = EXC_SYS;
      else                    st_d.exccode = 5'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) st_q <= '0;
    else       st_q <= st_d;
  end

  assign out_instr   = st_q.instr;
  assign out_pc      = st_q.pc;
  assign out_data    = st_q.data;
  assign out_wa      = st_q.wa;
  assign out_tnew    = st_q.tnew;
  assign out_bd      = st_q.bd;
  assign out_exccode = st_q.exccode;
  assign out_valid   = st_q.valid;

`ifdef PIPE_BUBBLE_CNT_EN
  logic [15:0] bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (stall && !Req && bubble_cnt_q != 16'hFFFF) bubble_cnt_d = bubble_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) bubble_cnt_q <= '0;
    else       bubble_cnt_q <= bubble_cnt_d;
  end

  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 96, width of the opaque operand payload (e.g. RD1, RD2 and EXT concatenated).
REQ-002 Parameter TNEW_W, default 2, width of the Tnew hazard countdown.
REQ-003 Parameter STALL_MODE, default 0, stall behaviour: 0 = insert bubble, 1 = hold contents.
REQ-004 Parameter HANDLER_PC, default 32'h0000_4180, PC loaded on flush.
REQ-005 The block SHALL use one clock and a synchronous, active-high reset.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 reset  in  1  synchronous active-high reset.
REQ-008 Req  in  1  exception/interrupt flush request.
REQ-009 stall  in  1  hazard stall for this stage boundary.
REQ-010 in_instr / in_pc  in  32 / 32  upstream instruction and PC.
REQ-011 in_data  in  DATA_W  upstream payload.
REQ-012 in_wa  in  5  upstream GRF write address.
REQ-013 in_tnew  in  TNEW_W  upstream Tnew.
REQ-014 in_bd  in  1  upstream branch-delay-slot flag.
REQ-015 in_exccode  in  5  upstream exception code, 0 = none.
REQ-016 in_ri / in_syscall  in  1 / 1  reserved-instruction and syscall detected upstream.
REQ-017 out_instr, out_pc, out_data, out_wa, out_tnew, out_bd, out_exccode  out  (widths as inputs)  registered stage outputs.
REQ-018 out_valid  out  1  1 = holds a real instruction, 0 = bubble/flushed.

Function
REQ-019 Priority per clk edge SHALL be reset > Req > stall > load.
REQ-020 Load (no reset/Req/stall): out_pc, out_data, out_wa, out_bd SHALL take inputs; out_valid <= 1.
REQ-021 Load: out_instr SHALL be 0 when in_ri=1, else in_instr.
REQ-022 Load: out_exccode SHALL be in_exccode if nonzero, else 10 if in_ri, else 8 if in_syscall, else 0.
REQ-023 Load: out_tnew SHALL be in_tnew-1 saturating at 0 (in_tnew=0 gives 0, no wrap).
REQ-024 Req: all outputs SHALL clear to 0 except out_pc <= HANDLER_PC; out_valid <= 0.
REQ-025 Stall, STALL_MODE=0: out_instr, out_data, out_wa, out_exccode, out_tnew, out_valid SHALL clear to 0; out_pc <= in_pc and out_bd <= in_bd (bubble carries PC/BD for EPC).
REQ-026 Stall, STALL_MODE=1: every output register SHALL hold its value.
REQ-027 Req asserted together with stall SHALL behave as Req only.
REQ-028 Load latency SHALL be exactly one clock; no combinational path from input to output.

Reset
REQ-029 On reset all outputs SHALL be 0, including out_pc, out_tnew and out_valid.
REQ-030 Reset asserted mid-stall SHALL clear state on that edge; first load follows the first edge with reset, Req and stall low.

Configuration
REQ-031 Macro PIPE_BUBBLE_CNT_EN defined: added output bubble_cnt [15:0] counts edges where stall applies (stall=1, reset=0, Req=0), saturating at 16'hFFFF, cleared by reset, unaffected by Req.
REQ-032 PIPE_BUBBLE_CNT_EN undefined: no bubble_cnt port and no counter logic; all other behaviour identical.

Verification
REQ-033 Load in_instr=32'h0000_0020, in_pc=32'h3000, in_tnew=2 -> next cycle out_instr=32'h20, out_pc=32'h3000, out_tnew=1, out_valid=1.
REQ-034 Load in_ri=1, in_syscall=1, in_exccode=0 -> out_instr=0, out_exccode=10; with in_exccode=4 -> out_exccode=4.
REQ-035 STALL_MODE=0, stall=1, in_pc=32'h3008, in_bd=1 -> out_instr=0, out_valid=0, out_pc=32'h3008, out_bd=1; STALL_MODE=1 -> outputs unchanged for 3 stalled cycles.
REQ-036 Req=1 and stall=1 together -> out_pc=32'h4180, all other outputs 0.
REQ-037 in_tnew=0 load -> out_tnew=0 (no wrap to 3).
REQ-038 PIPE_BUBBLE_CNT_EN: 5 stall cycles then 2 Req cycles -> bubble_cnt=5; reset -> 0.
